// File: rtl/seg_fun_pkg.sv
// seg_fun_pkg: debounce FSM state encoding and default timing constants
`timescale 1ns/1ps
package seg_fun_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
  localparam int DEF_N_BTN = 4;
  localparam int DEF_DEB_CYCLES = 100000;
  localparam bit DEF_REPEAT_EN = 1'b1;
  localparam int DEF_REPEAT_DELAY = 5000000;
  localparam int DEF_REPEAT_RATE = 1000000;
endpackage

// File: rtl/button_debounce_if.sv
// button_debounce_if: raw button pins in, debounced levels and event pulses out
`timescale 1ns/1ps
interface button_debounce_if #(parameter int N_BTN = 4);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_event;
  modport master(output btn_raw, input btn_level, btn_press, btn_release, btn_event);
  modport slave(input btn_raw, output btn_level, btn_press, btn_release, btn_event);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: one button - synchroniser, debounce FSM, press/release/repeat pulses
`timescale 1ns/1ps
module debounce_channel
  import seg_fun_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter bit REPEAT_EN = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  btn_state_t state, state_n;
  logic s1, s;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hold, hold_n;
  logic press_n, rel_n, rpt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s <= 1'b0;
      state <= RELEASED;
      cnt <= '0;
      hold <= '0;
      press <= 1'b0;
      rel <= 1'b0;
      rpt <= 1'b0;
    end else begin
      s1 <= raw;
      s <= s1;
      state <= state_n;
      cnt <= cnt_n;
      hold <= hold_n;
      press <= press_n;
      rel <= rel_n;
      rpt <= rpt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hold_n = hold;
    press_n = 1'b0;
    rel_n = 1'b0;
    rpt_n = 1'b0;
    case (state)
      RELEASED: if (s) begin
        state_n = PRESS_WAIT;
        cnt_n = CW'(1);
      end
      PRESS_WAIT: if (!s) begin
        state_n = RELEASED;
        cnt_n = '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        state_n = PRESSED;
        cnt_n = '0;
        press_n = 1'b1;
        hold_n = '0;
      end else cnt_n = cnt + 1'b1;
      PRESSED: if (!s) begin
        state_n = RELEASE_WAIT;
        cnt_n = CW'(1);
      end else if (REPEAT_EN && hold == HW'(REPEAT_DELAY - 1)) begin
        rpt_n = 1'b1;
        hold_n = HW'(REPEAT_DELAY - REPEAT_RATE);
      end else hold_n = (hold == HW'(REPEAT_DELAY)) ? hold : hold + 1'b1;
      default: if (s) begin
        state_n = PRESSED;
        cnt_n = '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        state_n = RELEASED;
        cnt_n = '0;
        rel_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
    endcase
  end
  assign level = (state == PRESSED) || (state == RELEASE_WAIT);
endmodule

// File: rtl/button_debounce.sv
// button_debounce: N independent debounced button channels with press/release/repeat events
`timescale 1ns/1ps
module button_debounce
  import seg_fun_pkg::*;
#(
  parameter int N_BTN = DEF_N_BTN,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter bit REPEAT_EN = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input logic clk,
  input logic rst,
  button_debounce_if.slave bus
);
  logic [N_BTN-1:0] level, press, rel, rpt;
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEB_CYCLES(DEB_CYCLES),
      .REPEAT_EN(REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .raw(bus.btn_raw[g]),
      .level(level[g]),
      .press(press[g]),
      .rel(rel[g]),
      .rpt(rpt[g])
    );
  end
  assign bus.btn_level = level;
  assign bus.btn_press = press;
  assign bus.btn_release = rel;
  assign bus.btn_event = press | rpt;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: vector table, directed corner sequences and random stimulus vs a run-length model
`timescale 1ns/1ps
module tb_button_debounce;
  localparam int DEB = 4, DLY = 20, RATE = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  button_debounce_if #(.N_BTN(4)) bus ();
  button_debounce_if #(.N_BTN(4)) bus0 ();
  assign bus0.btn_raw = bus.btn_raw;
  button_debounce #(.N_BTN(4), .DEB_CYCLES(DEB), .REPEAT_EN(1'b1), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  button_debounce #(.N_BTN(4), .DEB_CYCLES(DEB), .REPEAT_EN(1'b0), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  always #50 clk = ~clk;
  typedef struct packed {logic r; logic [3:0] raw, lvl, pr, rl, ev;} vec_t;
  vec_t vq[$];
  logic [3:0] m_s1 = '0, m_s = '0, m_lvl = '0, m_pr = '0, m_rl = '0, m_rp = '0;
  int run[4], age[4], hold_left[4];
  logic [3:0] r;
  function automatic void chk(string name, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction
  function automatic void add(int n, logic rr, logic [3:0] raw, logic [3:0] lvl, logic [3:0] pr, logic [3:0] rl, logic [3:0] ev);
    for (int i = 0; i < n; i++) vq.push_back('{rr, raw, lvl, pr, rl, ev});
  endfunction
  // A change is accepted after DEB consecutive synchronised samples that differ from the level;
  // repeats fire at hold ages DLY, DLY+RATE, ... where age counts settled pressed samples.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_s1 = '0; m_s = '0; m_lvl = '0; m_pr = '0; m_rl = '0; m_rp = '0;
      for (int c = 0; c < 4; c++) begin run[c] = 0; age[c] = 0; end
    end else begin
      for (int c = 0; c < 4; c++) begin
        int rp;
        rp = run[c];
        m_pr[c] = 1'b0; m_rl[c] = 1'b0; m_rp[c] = 1'b0;
        run[c] = (m_s[c] != m_lvl[c]) ? run[c] + 1 : 0;
        if (run[c] == DEB) begin
          m_lvl[c] = m_s[c]; m_pr[c] = m_s[c]; m_rl[c] = !m_s[c]; run[c] = 0; age[c] = 0;
        end else if (m_lvl[c] && m_s[c] && rp == 0) begin
          age[c]++;
          m_rp[c] = (age[c] >= DLY) && ((age[c] - DLY) % RATE == 0);
        end
      end
      m_s = m_s1;
      m_s1 = bus.btn_raw;
    end
    #1;
    chk("model_level", bus.btn_level, m_lvl);
    chk("model_press", bus.btn_press, m_pr);
    chk("model_release", bus.btn_release, m_rl);
    chk("model_event", bus.btn_event, m_pr | m_rp);
    chk("model_norep_level", bus0.btn_level, m_lvl);
    chk("model_norep_event", bus0.btn_event, m_pr);
  endtask
  initial begin
    bus.btn_raw = 4'hF;
    add(3, 1, 4'hF, 0, 0, 0, 0);
    add(5, 0, 4'hF, 0, 0, 0, 0);
    add(1, 0, 4'hF, 4'hF, 4'hF, 0, 4'hF);
    add(1, 0, 4'hF, 4'hF, 0, 0, 0);
    add(5, 0, 4'h0, 4'hF, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 4'hF, 0);
    add(1, 0, 4'h0, 0, 0, 0, 0);
    add(5, 0, 4'h2, 0, 0, 0, 0);
    add(1, 0, 4'h2, 4'h2, 4'h2, 0, 4'h2);
    add(1, 0, 4'h2, 4'h2, 0, 0, 0);
    add(5, 0, 4'h0, 4'h2, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 4'h2, 0);
    add(1, 0, 4'h0, 0, 0, 0, 0);
    foreach (vq[i]) begin
      rst = vq[i].r;
      bus.btn_raw = vq[i].raw;
      tick();
      chk($sformatf("tbl%0d_level", i), bus.btn_level, vq[i].lvl);
      chk($sformatf("tbl%0d_press", i), bus.btn_press, vq[i].pr);
      chk($sformatf("tbl%0d_release", i), bus.btn_release, vq[i].rl);
      chk($sformatf("tbl%0d_event", i), bus.btn_event, vq[i].ev);
    end
    for (int t = 0; t < 16; t++) begin
      bus.btn_raw = (t < 8 && t % 2 == 0) ? 4'h1 : 4'h0;
      tick();
      chk("bounce_level", bus.btn_level, 4'h0);
      chk("bounce_press", bus.btn_press, 4'h0);
      chk("bounce_event", bus.btn_event, 4'h0);
    end
    bus.btn_raw = 4'h4;
    for (int t = 1; t <= 60; t++) begin
      tick();
      chk($sformatf("repeat_event_t%0d", t), bus.btn_event, (t == 6 || (t >= 26 && (t - 26) % 8 == 0)) ? 4'h4 : 4'h0);
      chk($sformatf("norepeat_event_t%0d", t), bus0.btn_event, (t == 6) ? 4'h4 : 4'h0);
    end
    bus.btn_raw = 4'h0;
    repeat (8) tick();
    // Raw low across edges 11-12: FSM sees s=0 at 13,14 and recovers at 15, so three hold steps are lost.
    for (int t = 1; t <= 40; t++) begin
      bus.btn_raw = (t == 11 || t == 12) ? 4'h0 : 4'h8;
      tick();
      chk("glitch_release", bus.btn_release, 4'h0);
      if (t >= 6) chk("glitch_level", bus.btn_level, 4'h8);
      chk($sformatf("glitch_event_t%0d", t), bus.btn_event, (t == 6 || t == 29 || t == 37) ? 4'h8 : 4'h0);
    end
    bus.btn_raw = 4'h0;
    repeat (8) tick();
    bus.btn_raw = 4'hF;
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk($sformatf("simul_press_t%0d", t), bus.btn_press, (t == 6) ? 4'hF : 4'h0);
    end
    bus.btn_raw = 4'h0;
    repeat (8) tick();
    bus.btn_raw = 4'hF;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_level", bus.btn_level, 4'h0);
    chk("midrst_press", bus.btn_press, 4'h0);
    chk("midrst_event", bus.btn_event, 4'h0);
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk($sformatf("midrst_repress_t%0d", t), bus.btn_press, (t == 6) ? 4'hF : 4'h0);
    end
    bus.btn_raw = 4'h0;
    repeat (8) tick();
    for (int c = 0; c < 4; c++) hold_left[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      r = bus.btn_raw;
      for (int c = 0; c < 4; c++) begin
        if (hold_left[c] == 0) begin
          r[c] = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 60);
        end
        hold_left[c]--;
      end
      bus.btn_raw = r;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
